// File: rtl/ks_pwm_dac.sv
// Sample-rate master and audio output stage for the Karplus-Strong string voice:
// paces the string, captures and attenuates its output, and renders it as PWM.
module ks_pwm_dac #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [DIV_WIDTH-1:0]  sample_div_i,
  input  logic [2:0]            volume_i,
  input  logic [DATA_WIDTH-1:0] ks_sample_i,
  output logic                  freeze_o,
  output logic                  sample_strobe_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  pwm_o
);

  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [DIV_WIDTH-1:0]  DIV_MIN  = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0]         div_eff;
  logic [DIV_WIDTH-1:0]         div_last;
  logic [DIV_WIDTH-1:0]         div_cnt;
  logic                         tick;
  logic signed [DATA_WIDTH-1:0] atten;
  logic [DATA_WIDTH-1:0]        pwm_cnt;
  logic [DATA_WIDTH-1:0]        duty;

  // The >= compare (not ==) lets a shrinking divisor end the current period at once.
  always_comb begin
    div_eff  = (sample_div_i < DIV_MIN) ? DIV_MIN : sample_div_i;
    div_last = div_eff - DIV_WIDTH'(1);
    tick     = enable_i & (div_cnt >= div_last);
    atten    = $signed(ks_sample_i) >>> volume_i;
  end

  assign freeze_o = ~tick;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!enable_i || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Flipping the sign bit turns two's complement into offset binary.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sample_strobe_o <= 1'b0;
      sample_o        <= MIDSCALE;
    end else begin
      sample_strobe_o <= tick;
      if (tick) begin
        sample_o <= {~atten[DATA_WIDTH-1], atten[DATA_WIDTH-2:0]};
      end
    end
  end

  // Duty only reloads on the last count of a frame, so a period is never split.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= MIDSCALE;
      pwm_o   <= 1'b0;
    end else if (!enable_i) begin
      pwm_cnt <= '0;
      duty    <= MIDSCALE;
      pwm_o   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DATA_WIDTH'(1);
      pwm_o   <= (pwm_cnt < duty);
      if (pwm_cnt == CNT_MAX) begin
        duty <= sample_o;
      end
    end
  end

endmodule

// File: tb/tb_ks_pwm_dac.sv
// Self-checking bench for ks_pwm_dac: directed scenarios with fixed expectations
// plus a randomized run compared against a cycle-level behavioural model.
module tb_ks_pwm_dac;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [15:0] sample_div_i;
  logic [2:0]  volume_i;
  logic [7:0]  ks_sample_i;
  logic        freeze_o;
  logic        sample_strobe_o;
  logic [7:0]  sample_o;
  logic        pwm_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ks_pwm_dac #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i           (clk_i),
    .rst             (rst),
    .enable_i        (enable_i),
    .sample_div_i    (sample_div_i),
    .volume_i        (volume_i),
    .ks_sample_i     (ks_sample_i),
    .freeze_o        (freeze_o),
    .sample_strobe_o (sample_strobe_o),
    .sample_o        (sample_o),
    .pwm_o           (pwm_o)
  );

  function automatic int eff_div(input logic [15:0] d);
    return (d < 2) ? 2 : int'(d);
  endfunction

  // Attenuate by floor division by 2^vol, then bias by half scale.
  function automatic int to_sample(input logic [7:0] s, input logic [2:0] v);
    int sv;
    int p;
    int a;
    sv = (int'(s) >= 128) ? int'(s) - 256 : int'(s);
    p  = 1 << v;
    a  = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
    return a + 128;
  endfunction

  // Behavioural model: elapsed cycles in the current sample period, PWM frame phase.
  int m_since, m_phase, m_duty, m_sample;
  bit m_strobe, m_pwm, m_t;

  always @(posedge clk_i or posedge rst) begin
    if (rst) begin
      m_since = 0; m_phase = 0; m_duty = 128; m_sample = 128; m_strobe = 0; m_pwm = 0;
    end else if (!enable_i) begin
      m_since = 0; m_phase = 0; m_duty = 128; m_strobe = 0; m_pwm = 0;
    end else begin
      m_t     = (m_since + 1 >= eff_div(sample_div_i));
      m_pwm   = (m_phase < m_duty);
      if (m_phase == 255) m_duty = m_sample;
      m_phase = (m_phase + 1) % 256;
      m_strobe = m_t;
      if (m_t) begin
        m_sample = to_sample(ks_sample_i, volume_i);
        m_since  = 0;
      end else begin
        m_since = m_since + 1;
      end
    end
  end

  task automatic do_reset(input logic en, input logic [15:0] div,
                          input logic [7:0] ks, input logic [2:0] vol);
    @(negedge clk_i);
    rst = 1'b1; enable_i = en; sample_div_i = div; ks_sample_i = ks; volume_i = vol;
    @(negedge clk_i);
    @(negedge clk_i);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin @(negedge clk_i); @(negedge clk_i); #1; end
      n_cmp += 4;
      if (freeze_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_freeze got %b want 1", freeze_o); end
      if (sample_strobe_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobe got %b want 0", sample_strobe_o); end
      if (sample_o !== 8'h80) begin n_fail++; $display("[TB] FAIL reset_sample got %h want 80", sample_o); end
      if (pwm_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm got %b want 0", pwm_o); end
    end
  endtask

  task automatic test_divider();
    logic ef, es;
    do_reset(1'b1, 16'd10, 8'h00, 3'd0);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      ef = (k % 10 != 9);
      es = (k > 0) && (k % 10 == 0);
      n_cmp += 2;
      if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL div10_freeze k=%0d got %b want %b", k, freeze_o, ef); end
      if (sample_strobe_o !== es) begin n_fail++; $display("[TB] FAIL div10_strobe k=%0d got %b want %b", k, sample_strobe_o, es); end
    end
  endtask

  task automatic test_capture();
    logic [7:0] ks_tab [5]  = '{8'h40, 8'h80, 8'hFF, 8'h7F, 8'h00};
    logic [2:0] vol_tab [5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd3};
    logic [7:0] exp_tab [5] = '{8'hC0, 8'h60, 8'h7F, 8'hFF, 8'h80};
    logic [7:0] ev;
    bit found;
    do_reset(1'b1, 16'd4, 8'h00, 3'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      if (i < 5) begin
        ks_sample_i = ks_tab[i]; volume_i = vol_tab[i]; ev = exp_tab[i];
      end else begin
        ks_sample_i = 8'($urandom); volume_i = 3'($urandom_range(0, 7));
        ev = 8'(to_sample(ks_sample_i, volume_i));
      end
      found = 0;
      for (int w = 0; w < 20 && !found; w++) begin
        @(negedge clk_i); #1;
        if (sample_strobe_o === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found || sample_o !== ev)
        begin n_fail++; $display("[TB] FAIL capture i=%0d ks=%h vol=%0d got %h want %h strobe_seen=%0d", i, ks_sample_i, volume_i, sample_o, ev, found); end
    end
  endtask

  task automatic test_pwm_frames();
    int dtab [4] = '{128, 64, 64, 144};
    logic ep;
    do_reset(1'b1, 16'd2, 8'hC0, 3'd0);
    for (int k = 0; k <= 1024; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k == 600) ks_sample_i = 8'h10;
      #1;
      ep = (k == 0) ? 1'b0 : (((k - 1) % 256) < dtab[(k - 1) / 256]);
      n_cmp++;
      if (pwm_o !== ep) begin n_fail++; $display("[TB] FAIL pwm_frame k=%0d got %b want %b", k, pwm_o, ep); end
    end
  endtask

  task automatic test_wrap_tick();
    int dtab [3] = '{128, 128, 64};
    logic ep;
    do_reset(1'b1, 16'd256, 8'hC0, 3'd0);
    for (int k = 0; k <= 768; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      ep = (k == 0) ? 1'b0 : (((k - 1) % 256) < dtab[(k - 1) / 256]);
      n_cmp++;
      if (pwm_o !== ep) begin n_fail++; $display("[TB] FAIL wrap_tick_pwm k=%0d got %b want %b", k, pwm_o, ep); end
      if (k == 255 || k == 256) begin
        n_cmp++;
        if (k == 255 && freeze_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_tick_freeze got %b want 0", freeze_o); end
        if (k == 256 && sample_o !== 8'h40) begin n_fail++; $display("[TB] FAIL wrap_tick_sample got %h want 40", sample_o); end
      end
    end
  endtask

  task automatic test_div_edges();
    logic ef, es;
    for (int d = 0; d < 2; d++) begin
      do_reset(1'b1, 16'(d), 8'h00, 3'd0);
      for (int k = 0; k < 12; k++) begin
        if (k > 0) @(negedge clk_i);
        #1;
        ef = (k % 2 == 0);
        n_cmp++;
        if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL div_small d=%0d k=%0d got %b want %b", d, k, freeze_o, ef); end
      end
    end
    do_reset(1'b1, 16'd100, 8'h00, 3'd0);
    for (int k = 0; k <= 71; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k == 50) sample_div_i = 16'd5;
      #1;
      ef = !(k >= 50 && (k - 50) % 5 == 0);
      es = (k >= 51 && (k - 51) % 5 == 0);
      n_cmp += 2;
      if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL div_shrink_freeze k=%0d got %b want %b", k, freeze_o, ef); end
      if (sample_strobe_o !== es) begin n_fail++; $display("[TB] FAIL div_shrink_strobe k=%0d got %b want %b", k, sample_strobe_o, es); end
    end
  endtask

  task automatic test_enable_drop();
    logic ef, es, ep;
    do_reset(1'b1, 16'd10, 8'hC0, 3'd0);
    repeat (300) @(negedge clk_i);
    enable_i = 1'b0; ks_sample_i = 8'h10;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      n_cmp += 2;
      if (freeze_o !== 1'b1) begin n_fail++; $display("[TB] FAIL dis_freeze k=%0d got %b want 1", k, freeze_o); end
      if (sample_o !== 8'h40) begin n_fail++; $display("[TB] FAIL dis_sample k=%0d got %h want 40", k, sample_o); end
      if (k > 0) begin
        n_cmp += 2;
        if (pwm_o !== 1'b0) begin n_fail++; $display("[TB] FAIL dis_pwm k=%0d got %b want 0", k, pwm_o); end
        if (sample_strobe_o !== 1'b0) begin n_fail++; $display("[TB] FAIL dis_strobe k=%0d got %b want 0", k, sample_strobe_o); end
      end
    end
    @(negedge clk_i);
    enable_i = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      ef = (k % 10 != 9);
      es = (k > 0) && (k % 10 == 0);
      ep = (k == 0) ? 1'b0 : ((k - 1) < 128);
      n_cmp += 3;
      if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL reen_freeze k=%0d got %b want %b", k, freeze_o, ef); end
      if (sample_strobe_o !== es) begin n_fail++; $display("[TB] FAIL reen_strobe k=%0d got %b want %b", k, sample_strobe_o, es); end
      if (pwm_o !== ep) begin n_fail++; $display("[TB] FAIL reen_pwm k=%0d got %b want %b", k, pwm_o, ep); end
    end
  endtask

  task automatic test_async_reset();
    logic ef, es;
    do_reset(1'b1, 16'd3, 8'h40, 3'd0);
    repeat (20) @(negedge clk_i);
    #1;
    n_cmp++;
    if (sample_o !== 8'hC0) begin n_fail++; $display("[TB] FAIL arst_pre_sample got %h want c0", sample_o); end
    @(posedge clk_i);
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 4;
    if (freeze_o !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_freeze got %b want 1", freeze_o); end
    if (sample_strobe_o !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_strobe got %b want 0", sample_strobe_o); end
    if (sample_o !== 8'h80) begin n_fail++; $display("[TB] FAIL arst_sample got %h want 80", sample_o); end
    if (pwm_o !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_pwm got %b want 0", pwm_o); end
    @(negedge clk_i);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      ef = (k % 3 != 2);
      es = (k > 0) && (k % 3 == 0);
      n_cmp += 2;
      if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL arst_after_freeze k=%0d got %b want %b", k, freeze_o, ef); end
      if (sample_strobe_o !== es) begin n_fail++; $display("[TB] FAIL arst_after_strobe k=%0d got %b want %b", k, sample_strobe_o, es); end
    end
  endtask

  task automatic test_random();
    logic ef;
    do_reset(1'b1, 16'd5, 8'h00, 3'd0);
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk_i);
      if (enable_i) begin
        if ($urandom_range(0, 299) == 0) enable_i = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable_i = 1'b1;
      end
      if ($urandom_range(0, 39) == 0)
        sample_div_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(20, 60)) : 16'($urandom_range(0, 12));
      ks_sample_i = 8'($urandom);
      volume_i    = 3'($urandom_range(0, 7));
      #1;
      ef = !(enable_i && (m_since + 1 >= eff_div(sample_div_i)));
      n_cmp += 4;
      if (freeze_o !== ef) begin n_fail++; $display("[TB] FAIL rnd_freeze k=%0d got %b want %b", k, freeze_o, ef); end
      if (sample_strobe_o !== m_strobe) begin n_fail++; $display("[TB] FAIL rnd_strobe k=%0d got %b want %b", k, sample_strobe_o, m_strobe); end
      if (sample_o !== 8'(m_sample)) begin n_fail++; $display("[TB] FAIL rnd_sample k=%0d got %h want %h", k, sample_o, 8'(m_sample)); end
      if (pwm_o !== m_pwm) begin n_fail++; $display("[TB] FAIL rnd_pwm k=%0d got %b want %b", k, pwm_o, m_pwm); end
    end
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b1; sample_div_i = 16'd10; ks_sample_i = 8'h00; volume_i = 3'd0;
    $display("[TB] start");
    test_reset();
    test_divider();
    test_capture();
    test_pwm_frames();
    test_wrap_tick();
    test_div_edges();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
